// File: rtl/loctag_pkg.sv
// Shared types and frame geometry for the serial ADC reader.
package loctag_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StQuiet
    } state_e;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned LEAD_BITS  = 4;
    localparam int unsigned DATA_BITS  = 12;

    // Any set bit in the leading-zero field marks a corrupted frame.
    function automatic logic lead_err(input logic [FRAME_BITS-1:0] frame);
        return |frame[FRAME_BITS-1 -: LEAD_BITS];
    endfunction

endpackage

// File: rtl/adc_serial_reader_if.sv
// Control, ADC pin and result signals of the serial ADC reader.
interface adc_serial_reader_if;
    import loctag_pkg::*;

    logic                 start;
    logic                 run;
    logic                 adc_cs;
    logic                 adc_clk;
    logic                 adc_so;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  start, run, adc_so,
        output adc_cs, adc_clk, sample, sample_valid, frame_err, busy
    );

    modport slave (
        output start, run, adc_so,
        input  adc_cs, adc_clk, sample, sample_valid, frame_err, busy
    );

endinterface

// File: rtl/adc_sclk_gen.sv
// Half-period tick generator for the ADC serial clock; restart holds the count at zero.
module adc_sclk_gen #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o
);
    localparam logic [7:0] CntLast = 8'(HALF_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CntLast);
        cnt_d  = tick_o ? 8'd0 : cnt_q + 8'd1;
        if (restart_i) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_serial_reader.sv
// Serial ADC frame reader: 16-clock frames, 4 leading zeros + 12 data bits, MSB first.
// Define ADC_AVG_EN to publish a running average of the last four raw samples.
module adc_serial_reader
    import loctag_pkg::*;
#(
    parameter int unsigned HALF_DIV     = 4,
    parameter int unsigned QUIET_CYCLES = 8
) (
    input logic                 clk,
    input logic                 reset,
    adc_serial_reader_if.master bus
);
    localparam logic [7:0] QuietLast = 8'(QUIET_CYCLES - 1);
    localparam logic [4:0] FrameLen  = 5'(FRAME_BITS);

    state_e                state_q, state_d;
    logic                  adc_cs_q, adc_cs_d;
    logic                  adc_clk_q, adc_clk_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            quiet_cnt_q, quiet_cnt_d;
    logic [DATA_BITS-1:0]  sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  busy_q;
    logic                  tick, restart, frame_done;
    logic [DATA_BITS-1:0]  raw;

    assign raw     = shift_q[DATA_BITS-1:0];
    assign restart = (state_q == StIdle) || (state_q == StQuiet);

    adc_sclk_gen #(
        .HALF_DIV(HALF_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .reset    (reset),
        .restart_i(restart),
        .tick_o   (tick)
    );

    always_comb begin
        state_d     = state_q;
        adc_cs_d    = adc_cs_q;
        adc_clk_d   = adc_clk_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        frame_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start || bus.run) begin
                    state_d  = StSetup;
                    adc_cs_d = 1'b0;
                end
            end
            StSetup: begin
                if (tick) begin
                    state_d   = StShift;
                    adc_clk_d = 1'b0;
                    bit_cnt_d = 5'd0;
                end
            end
            StShift: begin
                if (tick) begin
                    if (!adc_clk_q) begin
                        // Rising adc_clk edge: the ADC has had a full low half to settle.
                        adc_clk_d = 1'b1;
                        shift_d   = {shift_q[FRAME_BITS-2:0], bus.adc_so};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else if (bit_cnt_q == FrameLen) begin
                        state_d     = StQuiet;
                        adc_cs_d    = 1'b1;
                        quiet_cnt_d = 8'd0;
                        frame_done  = 1'b1;
                    end else begin
                        adc_clk_d = 1'b0;
                    end
                end
            end
            StQuiet: begin
                if (quiet_cnt_q == QuietLast) begin
                    if (bus.run) begin
                        state_d  = StSetup;
                        adc_cs_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    quiet_cnt_d = quiet_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef ADC_AVG_EN
    localparam int unsigned SumW = DATA_BITS + 2;

    logic [DATA_BITS-1:0] hist_q [3];
    logic [DATA_BITS-1:0] hist_d [3];
    logic [1:0]           fill_q, fill_d;
    logic [SumW-1:0]      sum;

    always_comb begin
        sum      = SumW'(raw) + SumW'(hist_q[0]) + SumW'(hist_q[1]) + SumW'(hist_q[2]);
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        hist_d   = hist_q;
        fill_d   = fill_q;
        if (frame_done) begin
            hist_d[0] = raw;
            hist_d[1] = hist_q[0];
            hist_d[2] = hist_q[1];
            // Nothing is published until the window holds four real samples.
            if (fill_q == 2'd3) begin
                sample_d = sum[SumW-1:2];
                valid_d  = 1'b1;
                err_d    = lead_err(shift_q);
            end else begin
                fill_d = fill_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '{default: '0};
            fill_q <= 2'd0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
`else
    always_comb begin
        sample_d = frame_done ? raw : sample_q;
        valid_d  = frame_done;
        err_d    = frame_done && lead_err(shift_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            adc_cs_q    <= 1'b1;
            adc_clk_q   <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= 5'd0;
            quiet_cnt_q <= 8'd0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            adc_cs_q    <= adc_cs_d;
            adc_clk_q   <= adc_clk_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            busy_q      <= (state_d != StIdle);
        end
    end

    assign bus.adc_cs       = adc_cs_q;
    assign bus.adc_clk      = adc_clk_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.frame_err    = err_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: HALF_DIV=4 and HALF_DIV=1 instances with ADC models.
`timescale 1ns / 1ps
module tb_adc_serial_reader;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    adc_serial_reader_if a_if ();
    adc_serial_reader_if b_if ();

    adc_serial_reader #(
        .HALF_DIV    (4),
        .QUIET_CYCLES(8)
    ) u_dut_a (
        .clk  (clk),
        .reset(rst_a),
        .bus  (a_if.master)
    );

    adc_serial_reader #(
        .HALF_DIV    (1),
        .QUIET_CYCLES(8)
    ) u_dut_b (
        .clk  (clk),
        .reset(rst_b),
        .bus  (b_if.master)
    );

    // ADC models: a new word per chip-select fall, next bit driven after each adc_clk fall.
    logic [15:0] a_words [16];
    logic [15:0] b_words [16];
    logic [15:0] a_cur, b_cur;
    logic [3:0]  a_fidx = '0, b_fidx = '0, a_idx = '0, b_idx = '0;
    logic        a_cs_prev = 1'b1, a_clk_prev = 1'b1, b_cs_prev = 1'b1, b_clk_prev = 1'b1;
    int          a_viol = 0;

    always @(negedge clk) begin
        if (a_cs_prev && !a_if.adc_cs) begin
            a_cur  = a_words[a_fidx];
            a_fidx = a_fidx + 4'd1;
            a_idx  = 4'd15;
        end
        if (a_clk_prev && !a_if.adc_clk && !a_if.adc_cs) begin
            a_if.adc_so = a_cur[a_idx];
            a_idx       = a_idx - 4'd1;
        end
        a_cs_prev  = a_if.adc_cs;
        a_clk_prev = a_if.adc_clk;
        if (!a_if.adc_cs && !a_if.busy) a_viol++;
    end

    always @(negedge clk) begin
        if (b_cs_prev && !b_if.adc_cs) begin
            b_cur  = b_words[b_fidx];
            b_fidx = b_fidx + 4'd1;
            b_idx  = 4'd15;
        end
        if (b_clk_prev && !b_if.adc_clk && !b_if.adc_cs) begin
            b_if.adc_so = b_cur[b_idx];
            b_idx       = b_idx - 4'd1;
        end
        b_cs_prev  = b_if.adc_cs;
        b_clk_prev = b_if.adc_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a posedge; returns on the sampling edge of the valid pulse.
    task automatic frame_a(output int lat, output logic [11:0] smp, output logic err);
        int c0;
        lat = -1;
        smp = '0;
        err = 1'b0;
        a_if.start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        a_if.start = 1'b0;
        @(negedge clk);
        check_eq("busy_after_start", a_if.busy, 1);
        check_eq("cs_low_after_start", a_if.adc_cs, 0);
        for (int i = 0; i < 400; i++) begin
            if (a_if.sample_valid) begin
                lat = cyc - c0;
                smp = a_if.sample;
                err = a_if.frame_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 40 && a_if.busy; i++) @(negedge clk);
        check_eq("idle_after_quiet", a_if.busy, 0);
        @(posedge clk);
        #1;
    endtask

    int          lat, c0, n_valid, high_cnt, n_gaps, rises, r1, r2;
    logic [11:0] smp;
    logic        err, seen_low, pclk;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.start = 1'b0;
        a_if.run   = 1'b0;
        b_if.start = 1'b0;
        b_if.run   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cs", a_if.adc_cs, 1);
        check_eq("rst_adc_clk", a_if.adc_clk, 1);
        check_eq("rst_sample", a_if.sample, 0);
        check_eq("rst_valid", a_if.sample_valid, 0);
        check_eq("rst_frame_err", a_if.frame_err, 0);
        check_eq("rst_busy", a_if.busy, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;

`ifdef ADC_AVG_EN
        a_words[a_fidx]        = 16'd100;
        a_words[a_fidx + 4'd1] = 16'd200;
        a_words[a_fidx + 4'd2] = 16'd300;
        a_words[a_fidx + 4'd3] = 16'd400;
        a_words[a_fidx + 4'd4] = 16'd500;
        a_if.run = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (a_if.sample_valid) begin
                n_valid++;
                if (n_valid == 1) check_eq("avg_first", a_if.sample, 250);
                if (n_valid == 2) begin
                    check_eq("avg_second", a_if.sample, 350);
                    a_if.run = 1'b0;
                end
            end
        end
        check_eq("avg_valid_count", n_valid, 2);
`else
        // Single frame, clean leading zeros.
        a_words[a_fidx] = 16'h0ABC;
        frame_a(lat, smp, err);
        check_eq("f1_latency", lat, 133);
        check_eq("f1_sample", smp, 12'hABC);
        check_eq("f1_frame_err", err, 0);
        @(negedge clk);
        check_eq("f1_valid_one_cycle", a_if.sample_valid, 0);
        check_eq("f1_sample_hold", a_if.sample, 12'hABC);
        wait_idle_a();

        // Corrupted leading bit still updates the sample.
        a_words[a_fidx] = 16'h8123;
        frame_a(lat, smp, err);
        check_eq("f2_latency", lat, 133);
        check_eq("f2_sample", smp, 12'h123);
        check_eq("f2_frame_err", err, 1);
        wait_idle_a();

        // Back-to-back frames; run drops during the third frame.
        a_words[a_fidx]        = 16'h0111;
        a_words[a_fidx + 4'd1] = 16'h0222;
        a_words[a_fidx + 4'd2] = 16'h0333;
        a_if.run = 1'b1;
        n_valid  = 0;
        high_cnt = 0;
        n_gaps   = 0;
        seen_low = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (a_if.sample_valid) begin
                n_valid++;
                smp = a_if.sample;
            end
            if (a_if.adc_cs) begin
                high_cnt++;
            end else begin
                if (seen_low && high_cnt > 0) begin
                    n_gaps++;
                    check_eq("run_gap_cycles", high_cnt, 8);
                end
                seen_low = 1'b1;
                high_cnt = 0;
                if (n_valid == 2) a_if.run = 1'b0;
            end
        end
        check_eq("run_valid_count", n_valid, 3);
        check_eq("run_gap_count", n_gaps, 2);
        check_eq("run_last_sample", smp, 12'h333);
        check_eq("run_idle", a_if.busy, 0);
        @(posedge clk);
        #1;

        // Reset on the 10th adc_clk rise aborts the frame.
        a_words[a_fidx] = 16'h0FFF;
        a_if.start = 1'b1;
        @(posedge clk);
        #1;
        a_if.start = 1'b0;
        rises = 0;
        pclk  = a_if.adc_clk;
        for (int i = 0; i < 400 && rises < 10; i++) begin
            @(negedge clk);
            if (!pclk && a_if.adc_clk) rises++;
            pclk = a_if.adc_clk;
        end
        check_eq("abort_rises_reached", rises, 10);
        rst_a = 1'b1;
        @(negedge clk);
        check_eq("abort_cs", a_if.adc_cs, 1);
        check_eq("abort_adc_clk", a_if.adc_clk, 1);
        check_eq("abort_busy", a_if.busy, 0);
        check_eq("abort_valid", a_if.sample_valid, 0);
        check_eq("abort_sample", a_if.sample, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        n_valid = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_if.sample_valid) n_valid++;
        end
        check_eq("abort_no_valid", n_valid, 0);
        check_eq("abort_sample_kept", a_if.sample, 0);
        @(posedge clk);
        #1;

        // HALF_DIV=1: 2-cycle adc_clk, second start while busy is dropped.
        b_words[b_fidx] = 16'h0555;
        b_if.start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        b_if.start = 1'b0;
        n_valid = 0;
        lat = -1;
        r1  = -1;
        r2  = -1;
        smp = '0;
        pclk = b_if.adc_clk;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i == 3) begin
                check_eq("hd1_busy_at_extra_start", b_if.busy, 1);
                b_if.start = 1'b1;
            end
            if (i == 4) b_if.start = 1'b0;
            if (!pclk && b_if.adc_clk) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            pclk = b_if.adc_clk;
            if (b_if.sample_valid) begin
                n_valid++;
                if (lat < 0) begin
                    lat = cyc - c0;
                    smp = b_if.sample;
                end
            end
        end
        check_eq("hd1_sclk_period", r2 - r1, 2);
        check_eq("hd1_latency", lat, 34);
        check_eq("hd1_sample", smp, 12'h555);
        check_eq("hd1_valid_count", n_valid, 1);
`endif

        check_eq("cs_low_only_when_busy", a_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
